demux_1x2: RTL and testbench

Buffered 1-to-2 datapath demultiplexer. It is the inverse of the 2:1 mux in the datapath component library: one input word stream is steered by `sel` into one of two output channels. Each output channel has its own small FIFO with a valid/ready handshake, so a stalled consumer on one channel never drops words. It sits between a single producer and two independent consumers in the scheduled datapath.

---
 rtl/demux_1x2.sv | 120 ++++++++++++
 tb/tb_demux_1x2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x2.sv
// Buffered 1:2 demux: sel steers each accepted word into one of two FIFOs; 1-cycle latency to dk.
// in_ready drops when the selected FIFO is full; each channel drains on its own dk_ready.

module demux_1x2_fifo #(
   parameter int unsigned DATAWIDTH = 64,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [DATAWIDTH-1:0] wdat,
   input  logic                 pop_ready,
   output logic [DATAWIDTH-1:0] head,
   output logic                 head_valid,
   output logic                 full,
   output logic [CW-1:0]        count
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [DATAWIDTH-1:0] mem [0:DEPTH-1];
   logic [PW-1:0]        wptr;
   logic [PW-1:0]        rptr;
   logic [CW-1:0]        cnt;
   logic                 wr;
   logic                 rd;

   assign head_valid = (cnt != '0);
   assign full       = (cnt == CW'(DEPTH));
   assign count      = cnt;
   // A push into a full FIFO is dropped here too, so the FIFO protects itself.
   assign wr         = push && !full;
   assign rd         = head_valid && pop_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr) wptr <= wptr + PW'(1);
         if (rd) rptr <= rptr + PW'(1);
         case ({wr, rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is left uncleared by reset; the zeroed count masks stale words.
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= wdat;
   end

   assign head = head_valid ? mem[rptr] : '0;
endmodule

module demux_1x2 #(
   parameter int unsigned DATAWIDTH = 64,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] a,
   input  logic                 sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATAWIDTH-1:0] d0,
   output logic                 d0_valid,
   input  logic                 d0_ready,
   output logic [DATAWIDTH-1:0] d1,
   output logic                 d1_valid,
   input  logic                 d1_ready,
   output logic [CW-1:0]        cnt0,
   output logic [CW-1:0]        cnt1
);
   logic full0;
   logic full1;
   logic push0;
   logic push1;

   // in_ready looks only at sel and registered fullness, never at the consumer readies.
   assign in_ready = sel ? !full1 : !full0;
   assign push0    = in_valid && in_ready && !sel;
   assign push1    = in_valid && in_ready &&  sel;

   demux_1x2_fifo #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH),
      .CW        (CW)
   ) f0 (
      .clk        (Clk),
      .rst        (Rst),
      .push       (push0),
      .wdat       (a),
      .pop_ready  (d0_ready),
      .head       (d0),
      .head_valid (d0_valid),
      .full       (full0),
      .count      (cnt0)
   );

   demux_1x2_fifo #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH),
      .CW        (CW)
   ) f1 (
      .clk        (Clk),
      .rst        (Rst),
      .push       (push1),
      .wdat       (a),
      .pop_ready  (d1_ready),
      .head       (d1),
      .head_valid (d1_valid),
      .full       (full1),
      .count      (cnt1)
   );
endmodule

// File: tb/tb_demux_1x2.sv
// Directed and random checks of demux_1x2 against a queue-based channel model.
module tb_demux_1x2;
   localparam int DW    = 64;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [DW-1:0] a;
   logic          sel;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] d0, d1;
   logic          d0_valid, d1_valid;
   logic          d0_ready, d1_ready;
   logic [CW-1:0] cnt0, cnt1;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   demux_1x2 dut (
      .Clk(Clk), .Rst(Rst), .a(a), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
      .d0(d0), .d0_valid(d0_valid), .d0_ready(d0_ready),
      .d1(d1), .d1_valid(d1_valid), .d1_ready(d1_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [DW-1:0] e0, e1;
      logic          er;
      e0 = (q0.size() != 0) ? q0[0] : '0;
      e1 = (q1.size() != 0) ? q1[0] : '0;
      er = sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
      chk({tag, ":cnt0"},     DW'(cnt0),     DW'(q0.size()));
      chk({tag, ":cnt1"},     DW'(cnt1),     DW'(q1.size()));
      chk({tag, ":d0_valid"}, DW'(d0_valid), DW'(q0.size() != 0));
      chk({tag, ":d1_valid"}, DW'(d1_valid), DW'(q1.size() != 0));
      chk({tag, ":d0"},       d0,            e0);
      chk({tag, ":d1"},       d1,            e1);
      chk({tag, ":in_ready"}, DW'(in_ready), DW'(er));
   endtask

   // Advance one clock edge, applying the channel rules to the model queues.
   task automatic tick();
      bit            p0, p1, push, s;
      logic [DW-1:0] w;
      p0   = d0_ready && (q0.size() != 0);
      p1   = d1_ready && (q1.size() != 0);
      push = in_valid && (sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH));
      s    = sel;
      w    = a;
      @(posedge Clk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (push) begin
         if (s) q1.push_back(w);
         else   q0.push_back(w);
      end
      #1;
   endtask

   initial begin
      Rst = 1'b1; a = '0; sel = 1'b0; in_valid = 1'b0; d0_ready = 1'b0; d1_ready = 1'b0;
      #12 Rst = 1'b0;
      #1 check_all("reset_init");
      @(posedge Clk); #1;

      // Routing and latency
      a = 64'h1111; sel = 1'b0; in_valid = 1'b1; #1 check_all("route_a");
      tick();
      a = 64'h2222; sel = 1'b1; #1 check_all("route_b");
      chk("route_d0", d0, 64'h1111);
      chk("route_cnt0", DW'(cnt0), 64'd1);
      tick();
      in_valid = 1'b0; #1 check_all("route_c");
      chk("route_d1", d1, 64'h2222);
      chk("route_cnt1", DW'(cnt1), 64'd1);

      // Asynchronous reset mid-cycle with one word per channel
      #2 Rst = 1'b1;
      q0.delete(); q1.delete();
      #1 check_all("rst_mid");
      chk("rst_d0", d0, 64'h0);
      sel = 1'b0; #1 chk("rst_rdy_sel0", DW'(in_ready), 64'd1);
      sel = 1'b1; #1 chk("rst_rdy_sel1", DW'(in_ready), 64'd1);
      #2 Rst = 1'b0;
      @(posedge Clk); #1;

      // Full and backpressure
      sel = 1'b0; in_valid = 1'b1; a = 64'hA; tick();
      a = 64'hB; tick();
      in_valid = 1'b0; #1 check_all("full");
      chk("full_cnt0", DW'(cnt0), 64'd2);
      chk("full_rdy0", DW'(in_ready), 64'd0);
      sel = 1'b1; #1 chk("full_rdy1", DW'(in_ready), 64'd1);
      sel = 1'b0; a = 64'hC; in_valid = 1'b1; tick();
      check_all("held");
      d0_ready = 1'b1; #1 check_all("pulse");
      tick();
      d0_ready = 1'b0; #1 check_all("bubble");
      chk("bubble_d0", d0, 64'hB);
      chk("bubble_rdy", DW'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0; #1 check_all("c_in");
      chk("c_cnt0", DW'(cnt0), 64'd2);
      d0_ready = 1'b1;
      chk("order_b", d0, 64'hB); tick();
      chk("order_c", d0, 64'hC); tick();
      check_all("drained");
      d0_ready = 1'b0;

      // Wrap-around on channel 1 with a free-running consumer
      sel = 1'b1; d1_ready = 1'b1; in_valid = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         a = DW'(i); tick();
         check_all("wrap");
         chk("wrap_d1", d1, DW'(i));
         chk("wrap_le1", DW'(cnt1 <= 1), 64'd1);
      end
      in_valid = 1'b0; tick();
      check_all("wrap_end");
      d1_ready = 1'b0;

      // Simultaneous push+pop on ch0 with an independent pop on ch1
      sel = 1'b0; a = 64'h55; in_valid = 1'b1; tick();
      sel = 1'b1; a = 64'h66; tick();
      sel = 1'b0; a = 64'h77; d0_ready = 1'b1; d1_ready = 1'b1; #1 check_all("simul_pre");
      tick();
      in_valid = 1'b0; d0_ready = 1'b0; d1_ready = 1'b0; #1 check_all("simul");
      chk("simul_cnt0", DW'(cnt0), 64'd1);
      chk("simul_d0", d0, 64'h77);
      chk("simul_cnt1", DW'(cnt1), 64'd0);
      d0_ready = 1'b1; tick();

      // Empty pop is ignored
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("empty_pop");
         chk("empty_d0", d0, 64'h0);
      end
      d0_ready = 1'b0; sel = 1'b0; a = 64'h99; in_valid = 1'b1; tick();
      in_valid = 1'b0; #1 check_all("after_empty");
      chk("after_empty_d0", d0, 64'h99);
      d0_ready = 1'b1; tick(); d0_ready = 1'b0;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         a        = {$urandom, $urandom};
         sel      = 1'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         d0_ready = ($urandom_range(0, 2) != 0);
         d1_ready = ($urandom_range(0, 2) == 0);
         #1 check_all("rand");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
